bias_group_sequencer: RTL
=========================

// Module: bias_group_sequencer
// PURPOSE
//  Sequences per-channel bias addition for one conv layer.
//  - Consumes N_LANE 18-bit accumulator lanes per beat from the adder-tree output.
//  - Selects the bias bank of the current output-channel group from a concatenated
//    bus of constant BIAS_layer* bank outputs.
//  - Adds the bias with saturation and forwards the result downstream.
//  - Steps through NUM_GROUPS groups of pix_per_group beats each, then signals done.
// PARAMETERS
//  N_LANE      16  lanes per beat (equals the bias bank N_adder_tree)
//  NUM_GROUPS  4   output-channel groups (bias banks) per layer pass
//  DATA_W      18  signed two's-complement fixed-point width
//  PIX_W       12  width of the pixel-per-group counter
// PORTS
//  clk            in   1                          rising-edge clock
//  rst            in   1                          synchronous, active-high reset
//  start          in   1                          1-cycle pulse; begins a pass (ignored while busy)
//  pix_per_group  in   PIX_W                      beats per group, sampled at start
//  bias_bus       in   NUM_GROUPS*N_LANE*DATA_W   bank g at [g*N_LANE*DATA_W +: N_LANE*DATA_W]
//  acc_data       in   N_LANE*DATA_W              lane i at [i*DATA_W +: DATA_W]
//  acc_valid      in   1                          accumulator beat valid
//  acc_ready      out  1                          beat accepted when acc_valid&acc_ready
//  out_data       out  N_LANE*DATA_W              biased lanes
//  out_valid      out  1                          output beat valid
//  out_ready      in   1                          downstream accept
//  group_idx      out  clog2(NUM_GROUPS)          current group
//  busy           out  1                          high in RUN/FLUSH
//  done           out  1                          1-cycle pulse at pass end
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, done, busy, group_idx, pixel counter=0; out_data=0.
//  FSM: IDLE -start-> RUN -last beat of last group accepted-> FLUSH
//       FLUSH -(out_valid=0 or out_ready=1)-> IDLE; done pulses on this exit.
//  start: pix_per_group latched, counters cleared; pix_per_group=0 is treated as 1.
//  acc_ready = (state==RUN) && (!out_valid || out_ready); single output register.
//  Latency: 1 cycle, accept to out_valid.
//  out_valid/out_data hold stable until out_ready; no beat is dropped or duplicated.
//  Accepted beat: pix++; if pix==last, then pix=0 and group_idx++.
//    The group advance takes effect for the next beat, never the current one.
//  Lane math: sum = sext(acc)+sext(bias) in DATA_W+1 bits.
//    Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. 0x20000..0x1FFFF for 18 bits.
//  start while busy is ignored. rst mid-pass aborts: the pending output is discarded
//    and no done is produced.
//  group_idx never wraps within a pass; it returns to 0 only at IDLE entry.
// CONFIGURATION
//  BIAS_RELU_EN defined: after saturation, negative lanes are forced to 0 (fused ReLU).
//  Undefined: the saturated signed sum passes through unchanged.
// STRUCTURE
//  Package bias_seq_pkg holds:
//  - DATA_W default, state enum {IDLE,RUN,FLUSH}, function sat_add(a,b)
//  Sub-module bias_sat_add_lane: one lane adder, sat, and optional ReLU (combinational).
//    Instantiated N_LANE times via generate; FSM, counters and output reg live in top.
// TESTING
//  1 NUM_GROUPS=2, pix=3, 6 beats of acc=0, out_ready=1 ->
//    beats 0-2 carry bank0 biases, beats 3-5 bank1; done pulses exactly once.
//  2 lane acc=0x1FFFF, bias=0x00288 -> 0x1FFFF. lane acc=0x20000, bias=0x3FD80 -> 0x20000.
//  3 acc=100, bias=0x3FD80 (-640) -> 0x3FDE4 (-540) without BIAS_RELU_EN; 0 with it.
//  4 out_ready low 5 cycles mid-group -> acc_ready low, out_data frozen;
//    count of beats out equals beats in.
//  5 start asserted during RUN -> ignored; pix_per_group=0 -> one beat per group.
//  6 rst during group 1 -> next cycle out_valid=0, busy=0, group_idx=0;
//    no done; a new start runs a full pass.

Source files
------------

// File: rtl/bias_seq_pkg.sv
// Shared definitions for the bias group sequencer: default lane width,
// sequencer states and the saturating lane add.
package bias_seq_pkg;

  localparam int DATA_W_DEFAULT = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Sign-extended add, then clamp when the two top bits of the wide sum disagree.
  function automatic logic [DATA_W_DEFAULT-1:0] sat_add(
    input logic [DATA_W_DEFAULT-1:0] a,
    input logic [DATA_W_DEFAULT-1:0] b
  );
    logic [DATA_W_DEFAULT:0] sum;
    sum = {a[DATA_W_DEFAULT-1], a} + {b[DATA_W_DEFAULT-1], b};
    if (sum[DATA_W_DEFAULT] != sum[DATA_W_DEFAULT-1])
      sat_add = {sum[DATA_W_DEFAULT], {(DATA_W_DEFAULT-1){~sum[DATA_W_DEFAULT]}}};
    else
      sat_add = sum[DATA_W_DEFAULT-1:0];
  endfunction

endpackage

// File: rtl/bias_sat_add_lane.sv
// One lane: signed bias add with saturation, optional fused ReLU.
// Build option: define BIAS_RELU_EN to force negative results to zero.
module bias_sat_add_lane
  import bias_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] sat;

  if (DATA_W == DATA_W_DEFAULT) begin : g_pkg_width
    assign sat = sat_add(acc, bias);
  end else begin : g_any_width
    logic [DATA_W:0] sum;
    assign sum = {acc[DATA_W-1], acc} + {bias[DATA_W-1], bias};
    assign sat = (sum[DATA_W] != sum[DATA_W-1])
               ? {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}}
               : sum[DATA_W-1:0];
  end

`ifdef BIAS_RELU_EN
  assign result = sat[DATA_W-1] ? '0 : sat;
`else
  assign result = sat;
`endif

endmodule

// File: rtl/bias_group_sequencer.sv
// Adds the current output-channel group's bias to each accumulator beat and
// walks NUM_GROUPS groups per pass. Build option: BIAS_RELU_EN (fused ReLU).
module bias_group_sequencer
  import bias_seq_pkg::*;
#(
  parameter int N_LANE     = 16,
  parameter int NUM_GROUPS = 4,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int PIX_W      = 12,
  localparam int GRP_W     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [PIX_W-1:0]                     pix_per_group,
  input  logic [NUM_GROUPS*N_LANE*DATA_W-1:0]  bias_bus,
  input  logic [N_LANE*DATA_W-1:0]             acc_data,
  input  logic                                 acc_valid,
  output logic                                 acc_ready,
  output logic [N_LANE*DATA_W-1:0]             out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [GRP_W-1:0]                     group_idx,
  output logic                                 busy,
  output logic                                 done
);

  localparam int BEAT_W = N_LANE * DATA_W;

  state_t            state;
  logic [PIX_W-1:0]  pix;
  logic [PIX_W-1:0]  pix_last;
  logic [BEAT_W-1:0] bias_sel;
  logic [BEAT_W-1:0] biased;
  logic              accept;

  // The output register can take a new beat when empty or draining this cycle.
  assign acc_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept    = acc_valid && acc_ready;
  assign bias_sel  = bias_bus[group_idx*BEAT_W +: BEAT_W];

  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    bias_sat_add_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .acc    (acc_data[i*DATA_W +: DATA_W]),
      .bias   (bias_sel[i*DATA_W +: DATA_W]),
      .result (biased[i*DATA_W +: DATA_W])
    );
  end

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later lines see new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      group_idx <= '0;
      pix       <= '0;
      pix_last  <= '0;
      // NOTE: the wide data register is reset as well so downstream never
      // observes X on out_data after reset, even though out_valid gates it.
      out_data  <= '0;
    end else begin
      done <= 1'b0;

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= biased;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            pix       <= '0;
            group_idx <= '0;
            pix_last  <= (pix_per_group == '0) ? '0 : pix_per_group - 1'b1;
          end
        end

        RUN: begin
          if (accept) begin
            if (pix == pix_last) begin
              pix <= '0;
              // The last group holds its index until IDLE so it never wraps.
              if (group_idx == GRP_W'(NUM_GROUPS - 1))
                state <= FLUSH;
              else
                group_idx <= group_idx + 1'b1;
            end else begin
              pix <= pix + 1'b1;
            end
          end
        end

        FLUSH: begin
          if (!out_valid || out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            group_idx <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
